// File: rtl/control_multi_if.sv
// ----------------------------------------------------------------------------
// control_multi_if -- handshake / control bundle for the multi-cycle control
// unit. Clock and reset stay as plain ports on the module.
//   iOPCODE[10:0]  opcode field from IR
//   iMemReady      memory read/write completes this cycle
//   iALUDone       multi-cycle ALU result valid
//   o*             datapath controls, current state, retire / illegal pulses
// Modports: slave = control unit, master = driver of the inputs.
// ----------------------------------------------------------------------------
interface control_multi_if;
    logic [10:0] iOPCODE;
    logic        iMemReady;
    logic        iALUDone;
    logic        oPCWrite, oIRWrite, oIorD, oOrigAULA;
    logic [1:0]  oOrigBULA, oALUop, oBranch;
    logic        oReg2Loc, oMemRead, oMemWrite, oMemToReg, oRegWrite;
    logic [3:0]  oState;
    logic        oInstrDone, oIllegal;

    modport slave (
        input  iOPCODE, iMemReady, iALUDone,
        output oPCWrite, oIRWrite, oIorD, oOrigAULA, oOrigBULA, oALUop, oBranch,
               oReg2Loc, oMemRead, oMemWrite, oMemToReg, oRegWrite,
               oState, oInstrDone, oIllegal
    );
    modport master (
        output iOPCODE, iMemReady, iALUDone,
        input  oPCWrite, oIRWrite, oIorD, oOrigAULA, oOrigBULA, oALUop, oBranch,
               oReg2Loc, oMemRead, oMemWrite, oMemToReg, oRegWrite,
               oState, oInstrDone, oIllegal
    );
endinterface

// File: rtl/control_multi.sv
// ----------------------------------------------------------------------------
// control_multi -- multi-cycle LEGv8-style control FSM.
//   iCLK     system clock (rising edge)
//   iRST_n   asynchronous active-low reset
//   bus      control_multi_if.slave (opcode, memory/ALU handshakes, controls)
// Optional feature macro: MULDIV_WAIT_EN -- when defined, MUL/DIV-class
// opcodes wait in EX_WAIT for iALUDone before write-back.
// Outputs are Moore except the FETCH IR/PC load and the MEM_WR retire pulse,
// which are qualified by iMemReady in the completing cycle.
// ----------------------------------------------------------------------------
module control_multi (
    input  logic            iCLK,
    input  logic            iRST_n,
    control_multi_if.slave  bus
);
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EX_R = 4'd2, EX_I = 4'd3,
                           MEM_ADDR = 4'd4, MEM_RD = 4'd5, LD_WB = 4'd6,
                           MEM_WR = 4'd7, ALU_WB = 4'd8, BRANCH = 4'd9,
                           EX_WAIT = 4'd10;

    typedef enum logic [2:0] {C_ILL, C_R, C_I, C_LD, C_ST, C_CB, C_BC, C_MD} cls_t;

    logic [3:0] state_q, state_d;
    logic       run_q;                  // 0 until the first edge after reset release
    logic       is_st_q, is_st_d;       // store family, captured in DECODE
    logic       is_cb_q, is_cb_d;       // CBZ/CBNZ (vs B.cond), captured in DECODE
    logic       illegal_q, illegal_d;
    cls_t       cls;

`ifndef MULDIV_WAIT_EN
    wire unused_aludone = bus.iALUDone;
`endif

    // Opcode classes (11-bit opcode field)
    always_comb begin
        cls = C_ILL;
        casez (bus.iOPCODE)
            11'h458, 11'h658, 11'h450, 11'h550, 11'h650,
            11'h69A, 11'h69B:                                cls = C_R;   // ADD SUB AND ORR EOR LSR LSL
            11'b1001000100?, 11'b1101000100?,
            11'b1001001000?, 11'b1011001000?:                cls = C_I;   // ADDI SUBI ANDI ORRI
            11'h7C2, 11'h1C2, 11'h3C2, 11'h5C4:              cls = C_LD;  // LDUR LDURB LDURH LDURSW
            11'h7C0, 11'h1C0, 11'h3C0, 11'h5C0:              cls = C_ST;  // STUR STURB STURH STURW
            11'b1011010????:                                 cls = C_CB;  // CBZ CBNZ
            11'b01010100???:                                 cls = C_BC;  // B.cond
            11'h4D8, 11'h4DA, 11'h4DE, 11'h4DC,
            11'h4D6, 11'h4D4, 11'h4D2:                       cls = C_MD;  // MUL SMULH UMULH MULHSU DIV REM REMU
            default:                                         cls = C_ILL;
        endcase
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= FETCH;
            run_q     <= 1'b0;
            is_st_q   <= 1'b0;
            is_cb_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            is_st_q   <= is_st_d;
            is_cb_q   <= is_cb_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        is_st_d   = is_st_q;
        is_cb_d   = is_cb_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    if (bus.iMemReady) state_d = DECODE;
            DECODE: begin
                is_st_d = (cls == C_ST);
                is_cb_d = (cls == C_CB);
                case (cls)
                    C_R:        state_d = EX_R;
                    C_I:        state_d = EX_I;
                    C_LD, C_ST: state_d = MEM_ADDR;
                    C_CB, C_BC: state_d = BRANCH;
`ifdef MULDIV_WAIT_EN
                    C_MD:       state_d = EX_WAIT;
`else
                    C_MD:       state_d = EX_R;
`endif
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EX_R, EX_I: state_d = ALU_WB;
            ALU_WB:     state_d = FETCH;
            MEM_ADDR:   state_d = is_st_q ? MEM_WR : MEM_RD;
            MEM_RD:     if (bus.iMemReady) state_d = LD_WB;
            LD_WB:      state_d = FETCH;
            MEM_WR:     if (bus.iMemReady) state_d = FETCH;
            BRANCH:     state_d = FETCH;
`ifdef MULDIV_WAIT_EN
            EX_WAIT:    if (bus.iALUDone) state_d = ALU_WB;
`endif
            default:    state_d = FETCH;   // unused encodings recover
        endcase
        // Hold FETCH until the first edge after reset release
        if (!run_q) begin
            state_d   = FETCH;
            illegal_d = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        bus.oPCWrite   = 1'b0;
        bus.oIRWrite   = 1'b0;
        bus.oIorD      = 1'b0;
        bus.oOrigAULA  = 1'b0;
        bus.oOrigBULA  = 2'b00;
        bus.oALUop     = 2'b11;
        bus.oBranch    = 2'b00;
        bus.oReg2Loc   = 1'b0;
        bus.oMemRead   = 1'b0;
        bus.oMemWrite  = 1'b0;
        bus.oMemToReg  = 1'b0;
        bus.oRegWrite  = 1'b0;
        bus.oInstrDone = 1'b0;
        case (state_q)
            FETCH: begin
                bus.oMemRead  = 1'b1;
                bus.oOrigAULA = 1'b1;
                bus.oOrigBULA = 2'b01;
                bus.oALUop    = 2'b00;
                bus.oIRWrite  = bus.iMemReady;
                bus.oPCWrite  = bus.iMemReady;
            end
            DECODE: begin
                bus.oOrigAULA = 1'b1;
                bus.oOrigBULA = 2'b11;
                bus.oALUop    = 2'b00;
            end
            EX_R:     bus.oALUop = 2'b10;
            EX_I: begin
                bus.oOrigBULA = 2'b10;
                bus.oALUop    = 2'b10;
            end
            ALU_WB: begin
                bus.oRegWrite  = 1'b1;
                bus.oInstrDone = 1'b1;
            end
            MEM_ADDR: begin
                bus.oOrigBULA = 2'b10;
                bus.oALUop    = 2'b00;
                bus.oReg2Loc  = is_st_q;
            end
            MEM_RD: begin
                bus.oMemRead = 1'b1;
                bus.oIorD    = 1'b1;
            end
            LD_WB: begin
                bus.oRegWrite  = 1'b1;
                bus.oMemToReg  = 1'b1;
                bus.oInstrDone = 1'b1;
            end
            MEM_WR: begin
                bus.oMemWrite  = 1'b1;
                bus.oIorD      = 1'b1;
                bus.oReg2Loc   = 1'b1;
                bus.oInstrDone = bus.iMemReady;
            end
            BRANCH: begin
                bus.oReg2Loc   = 1'b1;
                bus.oALUop     = 2'b01;
                bus.oBranch    = is_cb_q ? 2'b01 : 2'b10;
                bus.oInstrDone = 1'b1;
            end
`ifdef MULDIV_WAIT_EN
            EX_WAIT:  bus.oALUop = 2'b10;
`endif
            default: ;
        endcase
        // Quiet until the first edge after reset release
        if (!run_q) begin
            bus.oPCWrite   = 1'b0;
            bus.oIRWrite   = 1'b0;
            bus.oMemRead   = 1'b0;
            bus.oMemWrite  = 1'b0;
            bus.oRegWrite  = 1'b0;
            bus.oInstrDone = 1'b0;
        end
    end

    assign bus.oState   = state_q;
    assign bus.oIllegal = illegal_q;

endmodule

// File: tb/tb_control_multi.sv
module tb_control_multi;
    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   npass = 0;

    control_multi_if bus ();
    control_multi dut (.iCLK(clk), .iRST_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [10:0]      op;
        logic             alu;
        int               len;
        logic [5:0][3:0]  path;
        int               rw, dn, mtr, mw, r2l, ill;
        logic [1:0]       br;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [5:0][3:0] pth(input int s0, s1, s2, s3, s4);
        pth = '0;
        pth[0] = s0[3:0]; pth[1] = s1[3:0]; pth[2] = s2[3:0];
        pth[3] = s3[3:0]; pth[4] = s4[3:0];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int rw, dn, mtr, mw, r2l, ill, pcw, bad, cnt;
        logic [1:0] br;
        logic [3:0] es;

        //        name      op       alu len path                 rw dn mtr mw r2l ill br
        tv[0] = '{"ADD",    11'h458, 0, 4, pth(0,1,2,8,0),        1, 1, 0, 0, 0, 0, 2'b00};
        tv[1] = '{"ADDI",   11'h488, 0, 4, pth(0,1,3,8,0),        1, 1, 0, 0, 0, 0, 2'b00};
        tv[2] = '{"LDUR",   11'h7C2, 0, 5, pth(0,1,4,5,6),        1, 1, 1, 0, 0, 0, 2'b00};
        tv[3] = '{"STUR",   11'h7C0, 0, 4, pth(0,1,4,7,0),        0, 1, 0, 1, 2, 0, 2'b00};
        tv[4] = '{"CBZ",    11'h5A0, 0, 3, pth(0,1,9,0,0),        0, 1, 0, 0, 1, 0, 2'b01};
        tv[5] = '{"BCOND",  11'h2A0, 0, 3, pth(0,1,9,0,0),        0, 1, 0, 0, 1, 0, 2'b10};
        tv[6] = '{"ILLEGAL",11'h000, 0, 2, pth(0,1,0,0,0),        0, 0, 0, 0, 0, 1, 2'b00};
        tv[7] = '{"SUB",    11'h658, 0, 4, pth(0,1,2,8,0),        1, 1, 0, 0, 0, 0, 2'b00};
`ifdef MULDIV_WAIT_EN
        tv[8] = '{"DIV",    11'h4D6, 1, 4, pth(0,1,10,8,0),       1, 1, 0, 0, 0, 0, 2'b00};
`else
        tv[8] = '{"DIV",    11'h4D6, 1, 4, pth(0,1,2,8,0),        1, 1, 0, 0, 0, 0, 2'b00};
`endif

        // ---- reset state and release ----
        rst_n = 1'b0;
        bus.iOPCODE = 11'h000; bus.iMemReady = 1'b0; bus.iALUDone = 1'b0;
        #12;
        chk("rst state", bus.oState, 0);
        chk("rst memread", bus.oMemRead, 0);
        chk("rst illegal", bus.oIllegal, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("pre-edge memread", bus.oMemRead, 0);
        tick();
        chk("first fetch memread", bus.oMemRead, 1);
        chk("fetch stall irwrite", bus.oIRWrite, 0);
        tick();
        chk("fetch stall state", bus.oState, 0);
        bus.iMemReady = 1'b1; #1;
        chk("fetch irwrite", bus.oIRWrite, 1);
        chk("fetch pcwrite", bus.oPCWrite, 1);

        // ---- table-driven instruction paths, iMemReady tied 1 ----
        foreach (tv[v]) begin
            bus.iOPCODE = tv[v].op; bus.iMemReady = 1'b1; bus.iALUDone = tv[v].alu;
            rw = 0; dn = 0; mtr = 0; mw = 0; r2l = 0; ill = 0; pcw = 0; bad = 0; br = 2'b00;
            #1;
            for (int k = 0; k <= tv[v].len; k++) begin
                es = (k == tv[v].len) ? 4'd0 : tv[v].path[k];
                chk({tv[v].name, " state"}, bus.oState, es);
                if (bus.oState == 4'd1) chk({tv[v].name, " decode origB"}, bus.oOrigBULA, 2'b11);
                if (bus.oMemRead && bus.oMemWrite) bad++;
                if (bus.oRegWrite && bus.oMemWrite) bad++;
                if (k > 0) begin
                    rw  += int'(bus.oRegWrite);
                    dn  += int'(bus.oInstrDone);
                    mtr += int'(bus.oMemToReg && bus.oRegWrite);
                    mw  += int'(bus.oMemWrite);
                    r2l += int'(bus.oReg2Loc);
                    ill += int'(bus.oIllegal);
                    br  |= bus.oBranch;
                    if (k < tv[v].len) pcw += int'(bus.oPCWrite);
                end
                if (k < tv[v].len) tick();
            end
            chk({tv[v].name, " regwrite cnt"}, rw, tv[v].rw);
            chk({tv[v].name, " done cnt"}, dn, tv[v].dn);
            chk({tv[v].name, " memtoreg cnt"}, mtr, tv[v].mtr);
            chk({tv[v].name, " memwrite cnt"}, mw, tv[v].mw);
            chk({tv[v].name, " reg2loc cnt"}, r2l, tv[v].r2l);
            chk({tv[v].name, " illegal cnt"}, ill, tv[v].ill);
            chk({tv[v].name, " branch"}, br, tv[v].br);
            chk({tv[v].name, " pcwrite cnt"}, pcw, 0);
            chk({tv[v].name, " exclusive"}, bad, 0);
        end

        // ---- LDUR with memory stalled 3 cycles in MEM_RD ----
        bus.iOPCODE = 11'h7C2; bus.iMemReady = 1'b1; bus.iALUDone = 1'b0;
        tick(); tick(); tick();
        chk("ld stall enter", bus.oState, 5);
        chk("ld memrd iord", {bus.oMemRead, bus.oIorD}, 2'b11);
        bus.iMemReady = 1'b0; #1;
        cnt = 0;
        for (int k = 0; k < 10 && bus.oState == 4'd5; k++) begin
            cnt++;
            if (cnt == 4) bus.iMemReady = 1'b1;
            tick();
        end
        chk("ld stall cycles", cnt, 4);
        chk("ld wb state", bus.oState, 6);
        chk("ld wb memtoreg/regwrite", {bus.oMemToReg, bus.oRegWrite, bus.oInstrDone}, 3'b111);
        tick();
        chk("ld back to fetch", bus.oState, 0);

        // ---- DIV with iALUDone arriving late ----
        bus.iOPCODE = 11'h4D6; bus.iALUDone = 1'b0;
        tick(); tick();
`ifdef MULDIV_WAIT_EN
        chk("div wait state", bus.oState, 10);
        chk("div wait aluop", {bus.oOrigBULA, bus.oALUop}, 4'b0010);
        cnt = 0;
        for (int k = 0; k < 12 && bus.oState == 4'd10; k++) begin
            cnt++;
            if (cnt == 5) bus.iALUDone = 1'b1;
            tick();
        end
        chk("div wait cycles", cnt, 5);
        bus.iALUDone = 1'b0;
`else
        chk("div ex_r state", bus.oState, 2);
        tick();
`endif
        chk("div alu_wb", bus.oState, 8);
        tick();
        chk("div back to fetch", bus.oState, 0);

        // ---- asynchronous reset while waiting in MEM_RD ----
        bus.iOPCODE = 11'h7C2; bus.iMemReady = 1'b1;
        tick(); tick();
        bus.iMemReady = 1'b0;
        tick();
        chk("rd wait state", bus.oState, 5);
        rst_n = 1'b0; #1;
        chk("async rst state", bus.oState, 0);
        chk("async rst enables", {bus.oMemRead, bus.oMemWrite, bus.oRegWrite,
                                  bus.oPCWrite, bus.oIRWrite, bus.oInstrDone, bus.oIllegal}, 7'b0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post rst fetch memread", bus.oMemRead, 1);
        chk("post rst state", bus.oState, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
